// File: rtl/btn_sync_array.sv
// Multi-channel button conditioner: synchroniser, debounce filter and edge pulses per channel.
// Define BTN_SYNC_AUTOREPEAT_EN to make `press` auto-repeat while a button is held.
module btn_sync_array #(
  parameter int N_CH        = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1000,
  parameter int RPT_DELAY   = 50000000,
  parameter int RPT_PERIOD  = 12500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] press
);

  localparam int CW = ($clog2(DEB_CYCLES) > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_TC = CW'(DEB_CYCLES - 1);

`ifdef BTN_SYNC_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW = ($clog2(RPT_MAX) > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RW-1:0] RPT_DELAY_LD  = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LD = RW'(RPT_PERIOD - 1);
`else
  localparam int rpt_cfg_unused = RPT_DELAY + RPT_PERIOD;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q;
    logic                   lvl_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   press_q;
    logic                   toggle;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign toggle = (s != lvl_q) && (cnt_q == DEB_TC);

    // Any agreement with the current level discards the pending candidate.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        if (s == lvl_q || toggle) cnt_q <= '0;
        else                      cnt_q <= cnt_q + 1'b1;
        lvl_q  <= lvl_q ^ toggle;
        rise_q <= toggle & ~lvl_q;
        fall_q <= toggle & lvl_q;
      end
    end

`ifdef BTN_SYNC_AUTOREPEAT_EN
    logic [RW-1:0] rpt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (toggle && !lvl_q) begin
          press_q <= 1'b1;
          rpt_q   <= RPT_DELAY_LD;
        end else if (!lvl_q || toggle) begin
          rpt_q <= '0;
        end else if (rpt_q == '0) begin
          press_q <= 1'b1;
          rpt_q   <= RPT_PERIOD_LD;
        end else begin
          rpt_q <= rpt_q - 1'b1;
        end
      end
    end
`else
    assign press_q = rise_q;
`endif

    assign level[i] = lvl_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign press[i] = press_q;
  end

endmodule
